// File: rtl/scan_chain_ctrl.sv
// Load / capture / unload sequencer for one muxed-D scan chain sharing CLK.
// Optional response compare against EXP: define SCAN_CHAIN_CTRL_COMPARE_EN.
//
// state   | meaning
// IDLE    | waiting for START, SE=0, SI=0
// SHIFT   | shifting the latched pattern into the chain, CHAIN_LEN edges
// CAPTURE | one functional clock with SE=0
// UNLOAD  | shifting the chain out into RESP, CHAIN_LEN edges
module scan_chain_ctrl #(
    parameter int CHAIN_LEN = 8,
    parameter int CNT_W     = $clog2(CHAIN_LEN) + 1
) (
    input  logic                 CLK,
    input  logic                 RN,
    input  logic                 START,
    input  logic                 ABORT,
    input  logic [CHAIN_LEN-1:0] PAT,
`ifdef SCAN_CHAIN_CTRL_COMPARE_EN
    input  logic [CHAIN_LEN-1:0] EXP,
    output logic                 MISMATCH,
`endif
    input  logic                 SO,
    output logic                 SE,
    output logic                 SI,
    output logic                 BUSY,
    output logic                 DONE,
    output logic [CHAIN_LEN-1:0] RESP
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SHIFT   = 2'd1,
        S_CAPTURE = 2'd2,
        S_UNLOAD  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CHAIN_LEN-1:0] pat_q, pat_d;
    logic [CHAIN_LEN-1:0] resp_q, resp_d;
    logic                 se_q, se_d;
    logic                 si_q, si_d;
    logic                 done_q, done_d;
    logic                 last_cnt;
    logic                 abort_op;
    logic                 start_acc;
`ifdef SCAN_CHAIN_CTRL_COMPARE_EN
    logic [CHAIN_LEN-1:0] exp_q, exp_d;
    logic                 mismatch_q, mismatch_d;
`endif

    assign last_cnt  = (cnt_q == CNT_W'(CHAIN_LEN - 1));
    assign abort_op  = ABORT && (state_q != S_IDLE);
    assign start_acc = START && !ABORT && (state_q == S_IDLE);

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            pat_q      <= '0;
            resp_q     <= '0;
            se_q       <= 1'b0;
            si_q       <= 1'b0;
            done_q     <= 1'b0;
`ifdef SCAN_CHAIN_CTRL_COMPARE_EN
            exp_q      <= '0;
            mismatch_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pat_q      <= pat_d;
            resp_q     <= resp_d;
            se_q       <= se_d;
            si_q       <= si_d;
            done_q     <= done_d;
`ifdef SCAN_CHAIN_CTRL_COMPARE_EN
            exp_q      <= exp_d;
            mismatch_q <= mismatch_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort_op) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:    if (start_acc) state_d = S_SHIFT;
                S_SHIFT:   if (last_cnt)  state_d = S_CAPTURE;
                S_CAPTURE:                state_d = S_UNLOAD;
                S_UNLOAD:  if (last_cnt)  state_d = S_IDLE;
                default:                  state_d = S_IDLE;
            endcase
        end
    end

    // SE/SI are computed one edge ahead so the chain sees them registered.
    always_comb begin
        cnt_d      = cnt_q;
        pat_d      = pat_q;
        resp_d     = resp_q;
        se_d       = 1'b0;
        si_d       = 1'b0;
        done_d     = 1'b0;
`ifdef SCAN_CHAIN_CTRL_COMPARE_EN
        exp_d      = exp_q;
        mismatch_d = mismatch_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start_acc) begin
                    pat_d      = PAT;
                    resp_d     = '0;
                    cnt_d      = '0;
                    se_d       = 1'b1;
                    si_d       = PAT[0];
`ifdef SCAN_CHAIN_CTRL_COMPARE_EN
                    exp_d      = EXP;
                    mismatch_d = 1'b0;
`endif
                end
            end
            S_SHIFT: begin
                if (last_cnt) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    se_d  = 1'b1;
                    for (int i = 0; i < CHAIN_LEN; i++) begin
                        if (CNT_W'(i) == cnt_q + CNT_W'(1)) si_d = pat_q[i];
                    end
                end
            end
            S_CAPTURE: begin
                cnt_d = '0;
                se_d  = 1'b1;
            end
            S_UNLOAD: begin
                for (int i = 0; i < CHAIN_LEN; i++) begin
                    if (cnt_q == CNT_W'(i)) resp_d[i] = SO;
                end
                if (last_cnt) begin
                    cnt_d      = '0;
                    done_d     = 1'b1;
`ifdef SCAN_CHAIN_CTRL_COMPARE_EN
                    mismatch_d = (resp_d != exp_q);
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    se_d  = 1'b1;
                end
            end
            default: begin
                cnt_d = '0;
            end
        endcase

        // Abort freezes RESP as it stands; the abort edge does not sample SO.
        if (abort_op) begin
            cnt_d      = '0;
            resp_d     = resp_q;
            se_d       = 1'b0;
            si_d       = 1'b0;
            done_d     = 1'b0;
`ifdef SCAN_CHAIN_CTRL_COMPARE_EN
            mismatch_d = 1'b0;
`endif
        end
    end

    always_comb begin
        BUSY = (state_q != S_IDLE);
        SE   = se_q;
        SI   = si_q;
        DONE = done_q;
        RESP = resp_q;
`ifdef SCAN_CHAIN_CTRL_COMPARE_EN
        MISMATCH = mismatch_q;
`endif
    end

endmodule
